// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: the queued {pc, instr} entry and
// the width helper for counters that must hold the value DEPTH itself.
package ifq_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  function automatic int ifq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side buses: instruction memory req/gnt/rvalid channel and the Decode
// valid/ready handoff with redirect. master = prefetch queue, slave = environment.
interface instr_prefetch_queue_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o32;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i32;
  logic        instr_valid_o;
  logic [31:0] instr_o32;
  logic [31:0] pc_o32;
  logic [31:0] pc_plus4_o32;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i32;

  modport master (
    output imem_req_o, imem_addr_o32, instr_valid_o, instr_o32, pc_o32, pc_plus4_o32,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i32, instr_ready_i, redirect_i, redirect_pc_i32
  );

  modport slave (
    input  imem_req_o, imem_addr_o32, instr_valid_o, instr_o32, pc_o32, pc_plus4_o32,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i32, instr_ready_i, redirect_i, redirect_pc_i32
  );
endinterface

// File: rtl/instr_prefetch_queue_fifo.sv
// Circular FIFO of {pc, instr} entries; push visible at the head the next cycle,
// flush empties it in one cycle. Caller guarantees no push when full / pop when empty.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = ifq_cnt_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  ifq_entry_t      i_dat,
  output logic            o_vld,
  output ifq_entry_t      o_head,
  output logic [CW-1:0]   o_occ
);

  ifq_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_occ;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_occ <= r_occ + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_vld  = (r_occ != '0);
  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch front-end: issues in-order word fetches while queue+in-flight credit remains,
// queues responses with their PC; redirect flushes and drops in-flight old-stream words.
module instr_prefetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  instr_prefetch_queue_if.master bus
);

  localparam int          CW      = ifq_cnt_w(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [31:0] STEP    = 32'(INSTR_BYTES);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_occ;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_outst_nxt;
  logic          w_credit;
  logic          w_grant;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_vld;
  logic [31:0]   w_redir_pc;
  ifq_entry_t    w_push_dat;
  ifq_entry_t    w_head;

  assign w_inflight  = {1'b0, w_occ} + {1'b0, r_outst};
  assign w_credit    = (w_inflight < DEPTH_C);
  assign w_grant     = bus.imem_req_o & bus.imem_gnt_i;
  assign w_outst_nxt = r_outst + CW'(w_grant) - CW'(bus.imem_rvalid_i);
  assign w_redir_pc  = bus.redirect_pc_i32 & ~32'h3;

  // Only live responses enter the queue; the redirect cycle's own response is old-stream.
  assign w_push     = bus.imem_rvalid_i & (r_drop == '0) & ~bus.redirect_i;
  assign w_pop      = w_fifo_vld & bus.instr_ready_i & ~bus.redirect_i;
  assign w_push_dat = '{pc: r_resp_pc, instr: bus.imem_rdata_i32};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (bus.redirect_i) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_drop     <= w_outst_nxt;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + STEP;
        if (bus.imem_rvalid_i && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_push) r_resp_pc <= r_resp_pc + STEP;
      end
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (reset_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_i),
    .i_dat   (w_push_dat),
    .o_vld   (w_fifo_vld),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

  // Outputs are forced low while reset is held, independent of register contents.
  assign bus.imem_req_o    = reset_i & w_credit;
  assign bus.imem_addr_o32 = reset_i ? r_fetch_pc : '0;
  assign bus.instr_valid_o = reset_i & w_fifo_vld;
  assign bus.instr_o32     = reset_i ? w_head.instr : '0;
  assign bus.pc_o32        = reset_i ? w_head.pc : '0;
  assign bus.pc_plus4_o32  = reset_i ? (w_head.pc + STEP) : '0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: in-order memory model with programmable latency and a
// PC scoreboard filled at grant time, plus per-scenario timing checks.
module tb_instr_prefetch_queue;
  import ifq_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  instr_prefetch_queue_if bus ();

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat   = 1;
  int          outst_m = 0;
  pend_t       pend[$];
  logic [31:0] sb[$];
  logic [31:0] exp_fetch = RESET_PC;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h8C00_1234;
  endfunction

  // Memory model and scoreboard: sample mid-cycle, answer just after the rising edge.
  initial begin : env
    logic [31:0] e;
    bus.imem_rvalid_i  = 1'b0;
    bus.imem_rdata_i32 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        sb.delete();
        exp_fetch = RESET_PC;
        outst_m   = 0;
      end else begin
        if (bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_pop: got pc=%h, required no instruction", bus.pc_o32);
          end else begin
            e = sb.pop_front();
            if (bus.pc_o32 !== e || bus.instr_o32 !== memf(e) || bus.pc_plus4_o32 !== e + 32'd4) begin
              bad++;
              $display("FAIL sb_data: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                       bus.pc_o32, bus.instr_o32, bus.pc_plus4_o32, e, memf(e), e + 32'd4);
            end
          end
        end
        if (bus.imem_req_o && bus.imem_gnt_i) begin
          total++;
          if (bus.imem_addr_o32 !== exp_fetch) begin
            bad++;
            $display("FAIL grant_addr: got %h, required %h", bus.imem_addr_o32, exp_fetch);
          end
          pend.push_back('{bus.imem_addr_o32, cyc + lat});
          if (!bus.redirect_i) begin
            sb.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
          end
          outst_m++;
        end
        if (bus.imem_rvalid_i) begin
          assert (outst_m > 0) else $error("response with nothing in flight");
          outst_m--;
        end
        assert (outst_m <= DEPTH && sb.size() <= DEPTH) else $error("credit invariant broken");
        if (bus.redirect_i) begin
          sb.delete();
          exp_fetch = bus.redirect_pc_i32 & ~32'h3;
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.imem_rvalid_i  = 1'b1;
        bus.imem_rdata_i32 = memf(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        bus.imem_rvalid_i  = 1'b0;
        bus.imem_rdata_i32 = '0;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cyc();
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.imem_req_o, bus.instr_valid_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ctl: got req=%b vld=%b, required 0 0", bus.imem_req_o, bus.instr_valid_o);
    end
    total++;
    if (bus.imem_addr_o32 !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr: got %h, required 0", bus.imem_addr_o32);
    end
    total++;
    if ({bus.instr_o32, bus.pc_o32, bus.pc_plus4_o32} !== 96'h0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h, required all 0", bus.instr_o32, bus.pc_o32, bus.pc_plus4_o32);
    end
    next_cyc();
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o32 !== RESET_PC) begin
      bad++;
      $display("FAIL first_req: got req=%b addr=%h, required 1 %h", bus.imem_req_o, bus.imem_addr_o32, RESET_PC);
    end
  endtask

  // One instruction per cycle from cycle 2 after reset release.
  task automatic test_stream();
    logic [31:0] e;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        e = 32'(4 * (k - 2));
        total++;
        if (k == 1 && bus.instr_valid_o !== 1'b0) begin
          bad++;
          $display("FAIL stream_early: got vld=%b, required 0", bus.instr_valid_o);
        end else if (k >= 2 && (bus.instr_valid_o !== 1'b1 || bus.pc_o32 !== e)) begin
          bad++;
          $display("FAIL stream_pc: cycle %0d got vld=%b pc=%h, required 1 %h", k, bus.instr_valid_o, bus.pc_o32, e);
        end
      end
    end
  endtask

  // Misaligned redirect near the top of the address space: alignment and wrap of pc/pc+4.
  task automatic test_wrap();
    logic [31:0] e;
    next_cyc();
    bus.redirect_i      = 1'b1;
    bus.redirect_pc_i32 = 32'hFFFF_FFF9;
    next_cyc();
    bus.redirect_i = 1'b0;
    total++;
    if (bus.imem_addr_o32 !== 32'hFFFF_FFF8 || bus.instr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL wrap_redir: got addr=%h vld=%b, required fffffff8 0", bus.imem_addr_o32, bus.instr_valid_o);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      e = 32'hFFFF_FFF8 + 32'(4 * (j - 2));
      total++;
      if (j < 2 && bus.instr_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL wrap_gap: step %0d got vld=1, required 0", j);
      end else if (j >= 2 && (bus.instr_valid_o !== 1'b1 || bus.pc_o32 !== e || bus.pc_plus4_o32 !== e + 32'd4)) begin
        bad++;
        $display("FAIL wrap_pc: step %0d got vld=%b pc=%h pc4=%h, required 1 %h %h",
                 j, bus.instr_valid_o, bus.pc_o32, bus.pc_plus4_o32, e, e + 32'd4);
      end
    end
  endtask

  task automatic test_gnt_hold();
    do_reset();
    repeat (3) next_cyc();
    bus.imem_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o32 !== 32'd12) begin
        bad++;
        $display("FAIL gnt_hold: cycle %0d got req=%b addr=%h, required 1 0000000c", i, bus.imem_req_o, bus.imem_addr_o32);
      end
    end
    next_cyc();
    bus.imem_gnt_i = 1'b1;
    next_cyc();
    total++;
    if (bus.imem_addr_o32 !== 32'd16) begin
      bad++;
      $display("FAIL gnt_advance: got addr=%h, required 00000010", bus.imem_addr_o32);
    end
  endtask

  task automatic test_stall();
    int g;
    next_cyc();
    bus.instr_ready_i = 1'b0;
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    g = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req_o && bus.imem_gnt_i) g++;
    end
    total++;
    if (g != DEPTH || bus.imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_credit: got grants=%0d req=%b, required %0d 0", g, bus.imem_req_o, DEPTH);
    end
    next_cyc();
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.instr_valid_o !== 1'b1 || bus.pc_o32 !== 32'(4 * i)) begin
        bad++;
        $display("FAIL stall_drain: step %0d got vld=%b pc=%h, required 1 %h", i, bus.instr_valid_o, bus.pc_o32, 32'(4 * i));
      end
      if (i == 1) begin
        total++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o32 !== 32'd16) begin
          bad++;
          $display("FAIL stall_resume: got req=%b addr=%h, required 1 00000010", bus.imem_req_o, bus.imem_addr_o32);
        end
      end
    end
  endtask

  task automatic test_redirect_stale();
    next_cyc();
    lat = 3;
    bus.imem_gnt_i = 1'b0;
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    bus.imem_gnt_i = 1'b1;
    next_cyc();
    next_cyc();
    bus.imem_gnt_i      = 1'b0;
    bus.redirect_i      = 1'b1;
    bus.redirect_pc_i32 = 32'h40;
    next_cyc();
    bus.redirect_i = 1'b0;
    bus.imem_gnt_i = 1'b1;
    total++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o32 !== 32'h40) begin
      bad++;
      $display("FAIL stale_addr: got req=%b addr=%h, required 1 00000040", bus.imem_req_o, bus.imem_addr_o32);
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      total++;
      if (j < 4 && bus.instr_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL stale_drop: step %0d got vld=1 pc=%h, required 0", j, bus.pc_o32);
      end else if (j == 4 && (bus.instr_valid_o !== 1'b1 || bus.pc_o32 !== 32'h40 || bus.instr_o32 !== memf(32'h40))) begin
        bad++;
        $display("FAIL stale_first: got vld=%b pc=%h instr=%h, required 1 00000040 %h",
                 bus.instr_valid_o, bus.pc_o32, bus.instr_o32, memf(32'h40));
      end
    end
  endtask

  task automatic test_redirect_collide();
    next_cyc();
    lat = 1;
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    repeat (4) next_cyc();
    bus.redirect_i      = 1'b1;
    bus.redirect_pc_i32 = 32'h103;
    @(negedge clk);
    total++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_rvalid_i !== 1'b1) begin
      bad++;
      $display("FAIL collide_setup: got req=%b rvalid=%b, required 1 1", bus.imem_req_o, bus.imem_rvalid_i);
    end
    next_cyc();
    bus.redirect_i = 1'b0;
    total++;
    if (bus.imem_addr_o32 !== 32'h100 || bus.instr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL collide_addr: got addr=%h vld=%b, required 00000100 0", bus.imem_addr_o32, bus.instr_valid_o);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total++;
      if (j < 2 && bus.instr_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL collide_drop: step %0d got vld=1 pc=%h, required 0", j, bus.pc_o32);
      end else if (j == 2 && (bus.instr_valid_o !== 1'b1 || bus.pc_o32 !== 32'h100)) begin
        bad++;
        $display("FAIL collide_first: got vld=%b pc=%h, required 1 00000100", bus.instr_valid_o, bus.pc_o32);
      end
    end
  endtask

  task automatic test_reset_mid();
    next_cyc();
    bus.instr_ready_i = 1'b0;
    repeat (8) next_cyc();
    total++;
    if (bus.instr_valid_o !== 1'b1 || bus.imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_full: got vld=%b req=%b, required 1 0", bus.instr_valid_o, bus.imem_req_o);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.instr_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0 || bus.pc_o32 !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset: got vld=%b req=%b pc=%h, required 0 0 0", bus.instr_valid_o, bus.imem_req_o, bus.pc_o32);
    end
    next_cyc();
    rst_n = 1'b1;
    bus.instr_ready_i = 1'b1;
    #1;
    total++;
    if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o32 !== RESET_PC) begin
      bad++;
      $display("FAIL mid_restart: got req=%b addr=%h, required 1 %h", bus.imem_req_o, bus.imem_addr_o32, RESET_PC);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        total++;
        if (bus.instr_valid_o !== 1'b1 || bus.pc_o32 !== RESET_PC + 32'(4 * (k - 2))) begin
          bad++;
          $display("FAIL mid_stream: cycle %0d got vld=%b pc=%h, required 1 %h",
                   k, bus.instr_valid_o, bus.pc_o32, RESET_PC + 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  initial begin
    bus.imem_gnt_i      = 1'b1;
    bus.instr_ready_i   = 1'b1;
    bus.redirect_i      = 1'b0;
    bus.redirect_pc_i32 = '0;
    test_reset();
    test_stream();
    test_wrap();
    test_gnt_hold();
    test_stall();
    test_redirect_stale();
    test_redirect_collide();
    test_reset_mid();
    repeat (3) next_cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
